// File: rtl/gp_pkg.sv
// gp_pkg: shared constants and types for the general-parameter table and pulse sequencer
package gp_pkg;
    localparam int PARAM_W = 32;
    localparam int N_CH = 3;
    localparam logic [1:0] ADDR_T_UP = 2'b00;
    localparam logic [1:0] ADDR_T_ON0 = 2'b01;
    localparam logic [1:0] ADDR_T_ON1 = 2'b10;
    localparam logic [1:0] ADDR_T_ON2 = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} gp_seq_state_t;
endpackage

// File: rtl/gp_pulse_channel.sv
// gp_pulse_channel: one pulse channel, shadowed on-time compared against the shared period counter
module gp_pulse_channel
    import gp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               busy,
    input  logic [PARAM_W-1:0] t_on,
    input  logic [PARAM_W-1:0] cnt,
    output logic               pulse
);
    logic [PARAM_W-1:0] t_on_s;
    always_ff @(posedge clk or posedge reset)
        if (reset) t_on_s <= '0;
        else if (load) t_on_s <= t_on;
    assign pulse = busy && (cnt < t_on_s);
endmodule

// File: rtl/gp_pulse_sequencer.sv
// gp_pulse_sequencer: periodic N_CH-channel pulse generator; table values are shadowed
// at period boundaries so a running period is never torn.
module gp_pulse_sequencer
    import gp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [PARAM_W-1:0] param [0:3],
    output logic [N_CH-1:0]    pulse,
    output logic               busy,
    output logic               period_start,
    output logic [PARAM_W-1:0] cnt,
    output logic               cfg_err
);
    gp_seq_state_t state;
    logic [PARAM_W-1:0] t_up_s;
    logic go, wrap, eff_run, load, t_up_bad;
    assign go = start && !stop;
    assign t_up_bad = param[0] == '0;
    assign wrap = cnt == t_up_s - 1'b1;
    // a start in DRAIN cancels the stop, so that cycle behaves exactly like RUN
    assign eff_run = state == RUN || (state == DRAIN && go);
    assign load = state == IDLE ? go && !t_up_bad : wrap && eff_run;
    assign busy = state != IDLE;
    assign period_start = busy && cnt == '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            t_up_s <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (load) t_up_s <= param[0];
            case (state)
                IDLE: if (go) begin
                    cfg_err <= t_up_bad;
                    state <= t_up_bad ? IDLE : RUN;
                end
                default: if (wrap) begin
                    cnt <= '0;
                    cfg_err <= eff_run && t_up_bad;
                    state <= !eff_run || t_up_bad ? IDLE : stop ? DRAIN : RUN;
                end else begin
                    cnt <= cnt + 1'b1;
                    state <= eff_run && !stop ? RUN : DRAIN;
                end
            endcase
        end
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        gp_pulse_channel u_ch (
            .clk(clk),
            .reset(reset),
            .load(load),
            .busy(busy),
            .t_on(param[i+1]),
            .cnt(cnt),
            .pulse(pulse[i])
        );
    end
endmodule

// File: tb/tb_gp_pulse_sequencer.sv
// tb_gp_pulse_sequencer: directed test-plan scenarios plus random traffic, every cycle
// compared against a period-level behavioural model of the sequencer.
module tb_gp_pulse_sequencer;
    import gp_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic [PARAM_W-1:0] param [0:3];
    logic [N_CH-1:0] pulse;
    logic busy, period_start, cfg_err;
    logic [PARAM_W-1:0] cnt;
    int compared = 0;
    int mismatched = 0;
    // model: mode 0 idle, 1 running, 2 finishing the current period
    int m_mode;
    longint unsigned m_pos, m_tup;
    longint unsigned m_ton [N_CH];
    bit m_err;

    always #5 clk = ~clk;

    gp_pulse_sequencer dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .param(param),
        .pulse(pulse),
        .busy(busy),
        .period_start(period_start),
        .cnt(cnt),
        .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pos = 0;
        m_tup = 0;
        m_err = 0;
        for (int i = 0; i < N_CH; i++) m_ton[i] = 0;
    endtask

    task automatic latch_period();
        m_tup = param[0];
        for (int i = 0; i < N_CH; i++) m_ton[i] = param[i+1];
    endtask

    task automatic model_edge();
        m_err = 0;
        if (m_mode == 0) begin
            if (start && !stop) begin
                if (param[0] == 0) m_err = 1;
                else begin
                    m_mode = 1;
                    m_pos = 0;
                    latch_period();
                end
            end
        end else begin
            if (m_mode == 2 && start && !stop) m_mode = 1;
            if (m_pos + 1 == m_tup) begin
                m_pos = 0;
                if (m_mode == 2) m_mode = 0;
                else begin
                    latch_period();
                    if (m_tup == 0) begin
                        m_mode = 0;
                        m_err = 1;
                    end else if (stop) m_mode = 2;
                end
            end else begin
                m_pos++;
                if (stop) m_mode = 2;
            end
        end
    endtask

    task automatic check_all();
        logic [N_CH-1:0] ep;
        bit b;
        b = m_mode != 0;
        for (int i = 0; i < N_CH; i++) ep[i] = b && (m_pos < m_ton[i]);
        chk("pulse", 64'(pulse), 64'(ep));
        chk("busy", 64'(busy), 64'(b));
        chk("period_start", 64'(period_start), 64'(b && m_pos == 0));
        chk("cnt", 64'(cnt), m_pos);
        chk("cfg_err", 64'(cfg_err), 64'(m_err));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (!reset) model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic goto_pos(input longint unsigned p);
        for (int k = 0; k < 40 && !(m_mode != 0 && m_pos == p); k++) run(1);
    endtask

    task automatic set_param(input int tup, input int a, input int b, input int c);
        param[0] = tup;
        param[1] = a;
        param[2] = b;
        param[3] = c;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        run(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        run(1);
        stop = 1'b0;
    endtask

    initial begin
        set_param(10, 3, 5, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
        run(3);
        pulse_start();
        run(32);
        set_param(10, 12, 5, 0);
        run(20);
        set_param(1, 12, 0, 1);
        run(15);
        set_param(8, 2, 3, 4);
        run(10);
        goto_pos(3);
        param[2] = 6;
        run(18);
        set_param(6, 1, 2, 3);
        run(10);
        goto_pos(2);
        pulse_stop();
        run(8);
        pulse_start();
        goto_pos(5);
        pulse_stop();
        run(14);
        pulse_start();
        goto_pos(1);
        pulse_stop();
        run(2);
        pulse_start();
        run(10);
        pulse_stop();
        run(10);
        param[0] = 0;
        pulse_start();
        run(3);
        param[0] = 5;
        pulse_start();
        run(3);
        param[0] = 0;
        run(8);
        set_param(6, 2, 7, 0);
        pulse_start();
        goto_pos(4);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        run(2);
        reset = 1'b0;
        run(5);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                int a;
                a = $urandom_range(0, 3);
                param[a] = a == 0 ? $urandom_range(0, 9) : $urandom_range(0, 12);
            end
            start = $urandom_range(0, 7) == 0;
            stop = $urandom_range(0, 14) == 0;
            run(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
